// File: rtl/bcd_scan_display.sv
// bcd_scan_display
// Four-digit multiplexed 7-segment driver. A packed BCD word is captured into
// a hold register on a load strobe. The held digits are scanned onto one
// shared active-low segment bus, using active-low digit selects. Every digit
// slot starts with one all-off cycle so that the previous digit cannot ghost.
//
// Parameters:
//   DIV  clocks per digit slot (1 blank + DIV-1 drive cycles), legal 2..256
// Ports:
//   clk  rising-edge clock
//   r    synchronous active-high reset (overrides LE)
//   LE   load enable, captures D on the rising edge while high
//   D    packed BCD digits, D[3:0] = digit 0 ... D[15:12] = digit 3
//   SEG  registered segments {g,f,e,d,c,b,a}, active-low
//   AN   registered digit selects, active-low one-hot or all-ones
//
// Optional feature: define BCD_SCAN_LZB_EN to enable leading-zero blanking.
// Digits 3..1 are then kept dark when they and every more-significant digit
// are zero. Digit 0 always shows.

module bcd_scan_display #(
  parameter int DIV = 4
) (
  input  logic        clk,
  input  logic        r,
  input  logic        LE,
  input  logic [15:0] D,
  output logic [6:0]  SEG,
  output logic [3:0]  AN
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  logic [15:0]   hold;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;

  logic [CW-1:0] cntNext;
  logic [1:0]    idxNext;
  logic [3:0]    nibble;
  logic          lzBlank;
  logic [6:0]    segNext;
  logic [3:0]    anNext;

  // Active-low segment patterns, ordered g..a. Codes 10..15 are not valid
  // BCD, so they show a lone dash on segment g. That way a miswired counter
  // is visible rather than silently hidden.
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  // Slot counter and digit index advance. The index steps only when the
  // counter wraps. The 2-bit index rolls 3 -> 0 naturally.
  always_comb begin
    cntNext = cnt + CW'(1);
    idxNext = idx;
    if (cnt == CNT_MAX) begin
      cntNext = '0;
      idxNext = idx + 2'd1;
    end
  end

  // Select the nibble of the digit currently being scanned. All decisions
  // below use the pre-edge hold value, so a capture on this edge shows up
  // one cycle later.
  always_comb begin
    nibble = hold[3:0];
    case (idx)
      2'd0: nibble = hold[3:0];
      2'd1: nibble = hold[7:4];
      2'd2: nibble = hold[11:8];
      2'd3: nibble = hold[15:12];
      default: nibble = hold[3:0];
    endcase
  end

  // Leading-zero blanking. A digit is dark when its own nibble and every
  // more-significant nibble are zero. Digit 0 is excluded so that a zero
  // word still reads "0".
  always_comb begin
    lzBlank = 1'b0;
`ifdef BCD_SCAN_LZB_EN
    case (idx)
      2'd3:    lzBlank = (hold[15:12] == 4'd0);
      2'd2:    lzBlank = (hold[15:8]  == 8'd0);
      2'd1:    lzBlank = (hold[15:4]  == 12'd0);
      default: lzBlank = 1'b0;
    endcase
`endif
  end

  // Next output values. Slot position 0 is the anti-ghosting blank cycle.
  // Selects are built from a one-hot shift, so at most one bit is ever low.
  always_comb begin
    anNext  = AN_OFF;
    segNext = SEG_OFF;
    if (cnt != '0 && !lzBlank) begin
      anNext  = ~(4'b0001 << idx);
      segNext = decode(nibble);
    end
  end

  // State and output registers. Reset wins over load. Capture runs
  // independently of where the scan currently is.
  always_ff @(posedge clk) begin
    if (r) begin
      hold <= 16'h0000;
      cnt  <= '0;
      idx  <= 2'd0;
      AN   <= AN_OFF;
      SEG  <= SEG_OFF;
    end else begin
      if (LE) begin
        hold <= D;
      end
      cnt <= cntNext;
      idx <= idxNext;
      AN  <= anNext;
      SEG <= segNext;
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb_bcd_scan_display
// Directed bench for bcd_scan_display with DIV=4 (16-cycle frame). It covers
// the following:
//   - reset overriding LE in the middle of a scan
//   - the scan order after reset release
//   - full-frame decoding
//   - holding the captured value while LE is low
//   - single-cycle capture latency
//   - invalid BCD codes shown as a dash
//   - leading zeros, shown or blanked depending on BCD_SCAN_LZB_EN
// A random soak at the end checks that at most one select is ever low. It also
// checks that every digit change passes through an all-off cycle.

module tb_bcd_scan_display;

  localparam logic [6:0] OFF  = 7'b1111111;
  localparam logic [6:0] S0   = 7'b1000000;
  localparam logic [6:0] S1   = 7'b1111001;
  localparam logic [6:0] S2   = 7'b0100100;
  localparam logic [6:0] S3   = 7'b0110000;
  localparam logic [6:0] S4   = 7'b0011001;
  localparam logic [6:0] S5   = 7'b0010010;
  localparam logic [6:0] S9   = 7'b0010000;
  localparam logic [6:0] DASH = 7'b0111111;

`ifdef BCD_SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        r;
  logic        LE;
  logic [15:0] D;
  logic [6:0]  SEG;
  logic [3:0]  AN;

  int nAsserts = 0;
  int nFails   = 0;

  bcd_scan_display #(.DIV(4)) dut (
    .clk (clk),
    .r   (r),
    .LE  (LE),
    .D   (D),
    .SEG (SEG),
    .AN  (AN)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Drive all inputs in one place, with blocking assignments, well away
  // from the active edge.
  task automatic applyStimulus(input logic rIn, input logic leIn, input logic [15:0] dIn);
    r  = rIn;
    LE = leIn;
    D  = dIn;
  endtask

  // Advance one rising edge, then settle 1 ns before sampling.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Compare both outputs against hand-computed values.
  task automatic checkOutput(input string tag, input logic [3:0] expAn, input logic [6:0] expSeg);
    nAsserts++;
    assert (AN === expAn && SEG === expSeg)
    else begin
      nFails++;
      $error("FAIL %s: observed AN=%b SEG=%b expected AN=%b SEG=%b", tag, AN, SEG, expAn, expSeg);
    end
  endtask

  // One digit slot: a blank edge, then three drive edges. LE is dropped
  // after the blank edge, so a load set up by the caller lasts exactly one cycle.
  task automatic checkSlot(input string tag, input int digit, input logic [6:0] expSeg, input bit show);
    logic [3:0] expAn;
    expAn = show ? ~(4'b0001 << digit) : 4'b1111;
    tick;
    checkOutput($sformatf("%s d%0d blank", tag, digit), 4'b1111, OFF);
    LE = 1'b0;
    for (int j = 1; j < 4; j++) begin
      tick;
      checkOutput($sformatf("%s d%0d drive%0d", tag, digit, j), expAn, show ? expSeg : OFF);
    end
  endtask

  // A whole frame, starting at the blank edge of digit 0. An optional load
  // happens on that first blank edge.
  task automatic runFrame(input string tag, input logic ld, input logic [15:0] d,
                          input logic [6:0] e0, input logic [6:0] e1,
                          input logic [6:0] e2, input logic [6:0] e3,
                          input logic [3:0] showMask);
    applyStimulus(1'b0, ld, d);
    checkSlot(tag, 0, e0, showMask[0]);
    checkSlot(tag, 1, e1, showMask[1]);
    checkSlot(tag, 2, e2, showMask[2]);
    checkSlot(tag, 3, e3, showMask[3]);
  endtask

  initial begin
    logic [3:0] prevAn;

    // Bring the design up, then let it scan part-way into a frame.
    applyStimulus(1'b1, 1'b0, 16'h0000);
    tick;
    applyStimulus(1'b0, 1'b0, 16'h0000);
    repeat (6) tick;

    // Reset mid-scan for 3 cycles while also requesting a load. Reset must
    // win, and the outputs must stay dark.
    applyStimulus(1'b1, 1'b1, 16'h8888);
    for (int i = 0; i < 3; i++) begin
      tick;
      checkOutput($sformatf("reset%0d", i), 4'b1111, OFF);
    end

    // After release: blank first, then digit 0 shows "0". The hold register
    // was cleared, so the 8888 load must not appear. Leading digits follow
    // the blanking option.
    runFrame("zero", 1'b0, 16'h0000, S0, S0, S0, S0, {~LZB, ~LZB, ~LZB, 1'b1});

    // Full frame of 1234, loaded on the first blank edge.
    runFrame("1234", 1'b1, 16'h1234, S4, S3, S2, S1, 4'b1111);

    // Hold: D changes with LE low, and the display stays 1234 for 2 frames.
    runFrame("hold1", 1'b0, 16'h9999, S4, S3, S2, S1, 4'b1111);
    runFrame("hold2", 1'b0, 16'h9999, S4, S3, S2, S1, 4'b1111);

    // Pulse LE mid-way through digit 0's drive cycles. The pulse edge itself
    // still shows the old "4". The following edge shows "9".
    applyStimulus(1'b0, 1'b0, 16'h9999);
    tick;
    checkOutput("pulse blank", 4'b1111, OFF);
    tick;
    checkOutput("pulse pre", 4'b1110, S4);
    applyStimulus(1'b0, 1'b1, 16'h9999);
    tick;
    checkOutput("pulse edge", 4'b1110, S4);
    applyStimulus(1'b0, 1'b0, 16'h9999);
    tick;
    checkOutput("pulse new", 4'b1110, S9);
    checkSlot("pulse", 1, S9, 1'b1);
    checkSlot("pulse", 2, S9, 1'b1);
    checkSlot("pulse", 3, S9, 1'b1);

    // Invalid BCD codes decode to a lone dash.
    runFrame("A0F5", 1'b1, 16'hA0F5, S5, DASH, S0, DASH, 4'b1111);

    // Leading zeros: digits 3 and 2 are dark only with blanking enabled.
    runFrame("0042", 1'b1, 16'h0042, S2, S4, S0, S0, {~LZB, ~LZB, 1'b1, 1'b1});

    // All zeros: with blanking enabled, only digit 0 remains, showing "0".
    runFrame("0000", 1'b1, 16'h0000, S0, S0, S0, S0, {~LZB, ~LZB, ~LZB, 1'b1});

    // Random soak with the structural invariants checked every cycle.
    prevAn = 4'b1111;
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), 16'($urandom));
      tick;
      nAsserts++;
      assert ($countones(~AN) <= 1)
      else begin
        nFails++;
        $error("FAIL onehot cycle %0d: observed AN=%b expected at most one low bit", i, AN);
      end
      nAsserts++;
      assert (prevAn == 4'b1111 || AN == 4'b1111 || AN == prevAn)
      else begin
        nFails++;
        $error("FAIL ghost cycle %0d: observed AN %b -> %b expected all-off between digits", i, prevAn, AN);
      end
      prevAn = AN;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Four-digit multiplexed 7-segment display driver that sits directly downstream of the 4-bit BCD counter stages. It captures a 16-bit packed BCD word (four counter `Q` outputs) on a load strobe and holds it. It then time-multiplexes the held digits onto one shared active-low segment bus with active-low digit selects. A blanking cycle is inserted at each digit change to suppress ghosting.

## Interface
- `DIV`, default 4: clocks per digit slot. Slot = 1 blank cycle + (`DIV`-1) drive cycles. Legal range 2..256.
- `clk`  in  1: rising-edge clock.
- `r`  in  1: reset. Synchronous and active-high.
- `LE`  in  1: load enable. Captures `D` on the rising edge while high.
- `D`  in  16: packed BCD digits. `D[3:0]` = digit 0 (least significant), `D[15:12]` = digit 3.
- `SEG`  out  7: segments {g,f,e,d,c,b,a}. Active-low, registered.
- `AN`  out  4: digit select. Active-low one-hot or all-ones, registered. `AN[i]` selects digit i.

## Operation
- **Internal state**
  - Hold register `H[15:0]`.
  - Slot counter `cnt`, 0..`DIV`-1.
  - Digit index `idx[1:0]`.
- **Reset** (edge with `r`=1): `H`=0, `cnt`=0, `idx`=0, `AN`=4'b1111, `SEG`=7'b1111111. `r` overrides `LE`.
- **Capture:** on an edge with `r`=0 and `LE`=1, `H`<=`D`. Otherwise `H` holds. Capture is independent of scan position; no handshake or ack.
- **Scan:** on each edge with `r`=0:
  - If `cnt`==`DIV`-1, then `cnt`<=0 and `idx`<=`idx`+1 (wraps 3->0).
  - Otherwise `cnt`<=`cnt`+1.
- **Outputs:** computed from pre-edge `cnt`, `idx`, `H`.
  - `cnt`==0 (blank cycle): `AN`<=4'b1111, `SEG`<=7'b1111111.
  - Otherwise: `AN`<=~(1<<`idx`), `SEG`<=decode(`H[4*idx+3:4*idx]`).
- **Decode** (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10..15 (invalid BCD) = 0111111, a lone dash (g only).
- **Invariant:** `AN` never has more than one bit low.

## Timing
- Frame = 4*`DIV` cycles. Each digit is driven for `DIV`-1 consecutive cycles, preceded by one all-off cycle.
- Sequence after reset release (`DIV`=4), counting edges after release:
  - Edge 1: blank.
  - Edges 2-4: digit 0 driven.
  - Edge 5: blank.
  - Edges 6-8: digit 1 driven; and so on.
- Capture-to-display latency:
  - `LE` at edge k updates `H` at k.
  - The new value appears on `SEG` at edge k+1 if that edge is a drive cycle of the changed digit.
  - Otherwise it appears at that digit's next drive cycle, at most 4*`DIV` cycles later.
- `LE` on the same edge as a digit change is allowed. The new `H` is used from the next edge.
- Reset mid-scan: outputs are all-off on the following edge. Scanning restarts at digit 0 with the blank cycle first. `H` is cleared, so the display shows 0 (or blanked zeros, see Configuration).
- `LE` held continuously: `H` tracks `D` every cycle with one-cycle display lag.

## Configuration
- Macro: `BCD_SCAN_LZB_EN`.
- **Defined:** leading-zero blanking.
  - Digit i (i=3,2,1) is blanked (`AN`=4'b1111, `SEG`=7'b1111111 for its drive cycles) when its nibble and all more-significant nibbles are 0.
  - Digit 0 is never blanked.
  - The decision uses the same pre-edge `H` as decode.
  - Slot timing is unchanged.
- **Undefined:** every digit is driven with its decoded pattern, including leading zeros.

## Test plan
- **Reset values:** assert `r` for 3 cycles mid-scan. Required: `AN`=1111 and `SEG`=1111111 each cycle. After release with `DIV`=4: edge 1 blank, edges 2-4 `AN`=1110, `SEG`=1000000.
- **Full frame:** `LE`=1 for one cycle with `D`=16'h1234, `DIV`=4. Over one frame, required in drive cycles:
  - `AN`=1110 with `SEG`=0011001 ("4")
  - `AN`=1101 with 0110000 ("3")
  - `AN`=1011 with 0100100 ("2")
  - `AN`=0111 with 1111001 ("1")
  - One all-off cycle between each.
- **Hold:** after loading 16'h1234, drive `D`=16'h9999 with `LE`=0 for 2 frames. Required: display remains 1234. Pulse `LE`: the next drive cycle shows 9 (0010000).
- **Invalid code:** load 16'hA0F5. Required: digits 3 and 1 show 0111111, digit 2 shows 1000000, digit 0 shows 0010010.
- **Leading-zero blanking:** load 16'h0042.
  - With `BCD_SCAN_LZB_EN`: digits 3 and 2 keep `AN`=1111 in their slots.
  - Without it: they show 1000000.
  - Also load 16'h0000: with the macro, only digit 0 is shown, as "0".
- **Invariant check:** `DIV`=2, random `LE`/`D`/`r` over 10k cycles. Assert `AN` is never more than one bit low, and every digit change is preceded by an all-off cycle.
